// File: rtl/serial_link_pkg.sv
// Shared FSM state encoding and line-level constants for the serial link transceiver.
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } link_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_link_bit_timer.sv
// Bit-period down-counter: load starts a full or half period, tick_c marks its last cycle
// and the counter auto-reloads a full period while enabled.
module serial_link_bit_timer #(
    parameter int unsigned  CLKS_PER_BIT = 16,
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic en,
    input  logic load,
    input  logic half,
    output logic tick_c
);

    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            count <= '0;
        end else if (load) begin
            count <= half ? HALF_M1 : FULL_M1;
        end else if (en) begin
            count <= (count == '0) ? FULL_M1 : count - CNT_W'(1);
        end
    end

    assign tick_c = en && (count == '0);

endmodule

// File: rtl/serial_link_xcvr.sv
// Full-duplex async serial transceiver with hardware shift engines and bit counters.
// Define SERIAL_LINK_PARITY_EN to add a parity bit (PARITY_ODD selects odd) and rx_parity_err.
module serial_link_xcvr
    import serial_link_pkg::*;
#(
    parameter int unsigned  DATA_W       = 8,
    parameter int unsigned  CLKS_PER_BIT = 16,
`ifdef SERIAL_LINK_PARITY_EN
    parameter bit           PARITY_ODD   = 1'b0,
`endif
    localparam int unsigned BIC_W        = $clog2(DATA_W + 1)
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_serial,
    output logic [BIC_W-1:0]  bics,
    input  logic              rx_serial,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic [BIC_W-1:0]  bicr,
    output logic              rx_overrun,
`ifdef SERIAL_LINK_PARITY_EN
    output logic              rx_parity_err,
`endif
    output logic              rx_frame_err
);

    localparam logic [BIC_W-1:0] LAST_BIT = BIC_W'(DATA_W - 1);
    localparam logic [BIC_W-1:0] ALL_BITS = BIC_W'(DATA_W);

    // ---------------- transmitter ----------------
    link_state_e       tx_state, tx_state_nxt;
    logic [DATA_W-1:0] tx_shreg, tx_shreg_nxt;
    logic              tx_serial_nxt, tx_busy_nxt, tx_done_nxt;
    logic [BIC_W-1:0]  bics_nxt;
    logic              tx_accept_c, tx_tick_c;
`ifdef SERIAL_LINK_PARITY_EN
    logic              tx_par, tx_par_nxt;
`endif

    serial_link_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .en          (tx_state != IDLE),
        .load        (tx_accept_c),
        .half        (1'b0),
        .tick_c      (tx_tick_c)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tx_state  <= IDLE;
            tx_shreg  <= '0;
            tx_serial <= LINE_IDLE;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            bics      <= '0;
`ifdef SERIAL_LINK_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            tx_state  <= tx_state_nxt;
            tx_shreg  <= tx_shreg_nxt;
            tx_serial <= tx_serial_nxt;
            tx_busy   <= tx_busy_nxt;
            tx_done   <= tx_done_nxt;
            bics      <= bics_nxt;
`ifdef SERIAL_LINK_PARITY_EN
            tx_par    <= tx_par_nxt;
`endif
        end
    end

    // A load in the last stop-bit cycle chains straight into the next start bit.
    always_comb begin
        tx_state_nxt  = tx_state;
        tx_shreg_nxt  = tx_shreg;
        tx_serial_nxt = tx_serial;
        tx_busy_nxt   = tx_busy;
        tx_done_nxt   = 1'b0;
        bics_nxt      = bics;
        tx_accept_c   = 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
        tx_par_nxt    = tx_par;
`endif
        case (tx_state)
            IDLE: begin
                tx_accept_c = tx_load;
            end
            START: begin
                if (tx_tick_c) begin
                    tx_serial_nxt = tx_shreg[0];
                    tx_shreg_nxt  = {1'b0, tx_shreg[DATA_W-1:1]};
                    tx_state_nxt  = DATA;
                end
            end
            DATA: begin
                if (tx_tick_c) begin
                    if (bics != ALL_BITS) bics_nxt = bics + BIC_W'(1);
                    if (bics == LAST_BIT) begin
`ifdef SERIAL_LINK_PARITY_EN
                        tx_state_nxt  = PARITY;
                        tx_serial_nxt = tx_par;
`else
                        tx_state_nxt  = STOP;
                        tx_serial_nxt = LINE_IDLE;
`endif
                    end else begin
                        tx_serial_nxt = tx_shreg[0];
                        tx_shreg_nxt  = {1'b0, tx_shreg[DATA_W-1:1]};
                    end
                end
            end
`ifdef SERIAL_LINK_PARITY_EN
            PARITY: begin
                if (tx_tick_c) begin
                    tx_state_nxt  = STOP;
                    tx_serial_nxt = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                if (tx_tick_c) begin
                    tx_done_nxt  = 1'b1;
                    tx_busy_nxt  = 1'b0;
                    tx_state_nxt = IDLE;
                    tx_accept_c  = tx_load;
                end
            end
            default: tx_state_nxt = IDLE;
        endcase

        if (tx_accept_c) begin
            tx_shreg_nxt  = tx_data;
            tx_serial_nxt = START_BIT;
            tx_busy_nxt   = 1'b1;
            bics_nxt      = '0;
            tx_state_nxt  = START;
`ifdef SERIAL_LINK_PARITY_EN
            tx_par_nxt    = (^tx_data) ^ PARITY_ODD;
`endif
        end
    end

    // ---------------- receiver ----------------
    link_state_e       rx_state, rx_state_nxt;
    logic [1:0]        rx_sync;
    logic              rx_prev;
    logic [DATA_W-1:0] rx_shreg, rx_shreg_nxt;
    logic [DATA_W-1:0] rx_data_nxt;
    logic              rx_valid_nxt, rx_overrun_nxt, rx_frame_err_nxt;
    logic [BIC_W-1:0]  bicr_nxt;
    logic              rx_fall_c, rx_tick_c;
`ifdef SERIAL_LINK_PARITY_EN
    logic              rx_pbad, rx_pbad_nxt, rx_parity_err_nxt;
`endif

    assign rx_fall_c = (rx_prev == LINE_IDLE) && (rx_sync[1] == START_BIT);

    serial_link_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .en          (rx_state != IDLE),
        .load        (rx_state == IDLE && rx_fall_c),
        .half        (1'b1),
        .tick_c      (rx_tick_c)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rx_state      <= IDLE;
            rx_sync       <= {LINE_IDLE, LINE_IDLE};
            rx_prev       <= LINE_IDLE;
            rx_shreg      <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_frame_err  <= 1'b0;
            bicr          <= '0;
`ifdef SERIAL_LINK_PARITY_EN
            rx_pbad       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_state      <= rx_state_nxt;
            rx_sync       <= {rx_sync[0], rx_serial};
            rx_prev       <= rx_sync[1];
            rx_shreg      <= rx_shreg_nxt;
            rx_data       <= rx_data_nxt;
            rx_valid      <= rx_valid_nxt;
            rx_overrun    <= rx_overrun_nxt;
            rx_frame_err  <= rx_frame_err_nxt;
            bicr          <= bicr_nxt;
`ifdef SERIAL_LINK_PARITY_EN
            rx_pbad       <= rx_pbad_nxt;
            rx_parity_err <= rx_parity_err_nxt;
`endif
        end
    end

    // Acknowledge clears first so that a completion in the same cycle takes priority.
    always_comb begin
        rx_state_nxt      = rx_state;
        rx_shreg_nxt      = rx_shreg;
        rx_data_nxt       = rx_data;
        rx_valid_nxt      = rx_valid;
        rx_overrun_nxt    = rx_overrun;
        rx_frame_err_nxt  = rx_frame_err;
        bicr_nxt          = bicr;
`ifdef SERIAL_LINK_PARITY_EN
        rx_pbad_nxt       = rx_pbad;
        rx_parity_err_nxt = rx_parity_err;
`endif
        if (rx_ack) begin
            rx_valid_nxt      = 1'b0;
            rx_overrun_nxt    = 1'b0;
            rx_frame_err_nxt  = 1'b0;
`ifdef SERIAL_LINK_PARITY_EN
            rx_parity_err_nxt = 1'b0;
`endif
        end
        case (rx_state)
            IDLE: begin
                if (rx_fall_c) begin
                    bicr_nxt     = '0;
                    rx_state_nxt = START;
`ifdef SERIAL_LINK_PARITY_EN
                    rx_pbad_nxt  = 1'b0;
`endif
                end
            end
            START: begin
                if (rx_tick_c) begin
                    rx_state_nxt = (rx_sync[1] == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (rx_tick_c) begin
                    rx_shreg_nxt = {rx_sync[1], rx_shreg[DATA_W-1:1]};
                    if (bicr != ALL_BITS) bicr_nxt = bicr + BIC_W'(1);
                    if (bicr == LAST_BIT) begin
`ifdef SERIAL_LINK_PARITY_EN
                        rx_state_nxt = PARITY;
`else
                        rx_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_LINK_PARITY_EN
            PARITY: begin
                if (rx_tick_c) begin
                    rx_pbad_nxt  = rx_sync[1] != ((^rx_shreg) ^ PARITY_ODD);
                    if (rx_pbad_nxt) rx_parity_err_nxt = 1'b1;
                    rx_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (rx_tick_c) begin
                    rx_state_nxt = IDLE;
                    if (rx_sync[1] != LINE_IDLE) begin
                        rx_frame_err_nxt = 1'b1;
`ifdef SERIAL_LINK_PARITY_EN
                    end else if (rx_pbad) begin
                        rx_frame_err_nxt = rx_frame_err_nxt;
`endif
                    end else if (rx_valid) begin
                        rx_overrun_nxt = 1'b1;
                    end else begin
                        rx_data_nxt  = rx_shreg;
                        rx_valid_nxt = 1'b1;
                    end
                end
            end
            default: rx_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_link_xcvr.sv
// Directed self-checking bench for serial_link_xcvr (DATA_W=8, CLKS_PER_BIT=16).
module tb_serial_link_xcvr;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CPB    = 16;
    localparam int unsigned BIC_W  = 4;
`ifdef SERIAL_LINK_PARITY_EN
    localparam int unsigned NBITS  = DATA_W + 3;
`else
    localparam int unsigned NBITS  = DATA_W + 2;
`endif

    logic              clk_clk = 1'b0;
    logic              reset_reset = 1'b1;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_load = 1'b0;
    logic              tx_busy, tx_done, tx_serial;
    logic [BIC_W-1:0]  bics, bicr;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, rx_overrun, rx_frame_err;
    logic              rx_ack = 1'b0;
    logic              loop_en = 1'b0;
    logic              rx_drv = 1'b1;
    logic              rx_line;
`ifdef SERIAL_LINK_PARITY_EN
    logic              rx_parity_err;
`endif

    int checks = 0;
    int failures = 0;

    assign rx_line = loop_en ? tx_serial : rx_drv;

    always #5 clk_clk = ~clk_clk;

    serial_link_xcvr dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_serial    (tx_serial),
        .bics         (bics),
        .rx_serial    (rx_line),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .bicr         (bicr),
        .rx_overrun   (rx_overrun),
`ifdef SERIAL_LINK_PARITY_EN
        .rx_parity_err(rx_parity_err),
`endif
        .rx_frame_err (rx_frame_err)
    );

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Expected line level for bit n of a frame carrying d (start, LSB-first data, [even parity], stop).
    function automatic logic frame_bit(input logic [DATA_W-1:0] d, input int n);
        logic [DATA_W-1:0] v;
        v = d;
        if (n == 0) return 1'b0;
        if (n <= int'(DATA_W)) return v[n-1];
        if (n == int'(NBITS) - 1) return 1'b1;
        return ^v;
    endfunction

    task automatic send_rx(input logic [DATA_W-1:0] d, input logic stop, input logic bad_par);
        logic b;
        for (int n = 0; n < int'(NBITS); n++) begin
            b = frame_bit(d, n);
            if (n == int'(DATA_W) + 1 && NBITS == DATA_W + 3) b = b ^ bad_par;
            if (n == int'(NBITS) - 1) b = stop;
            rx_drv = b;
            repeat (CPB) tick();
        end
        rx_drv = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        tx_data = 8'hFF;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        rx_drv  = 1'b0;
        repeat (40) tick();
        reset_reset = 1'b1;
        rx_drv = 1'b1;
        repeat (3) tick();
        reset_reset = 1'b0;
        checks++; if (tx_serial !== 1'b1) begin failures++; $display("FAIL reset_tx_serial got=%b want=1", tx_serial); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_tx_busy got=%b want=0", tx_busy); end
        checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_tx_done got=%b want=0", tx_done); end
        checks++; if (bics !== 4'd0) begin failures++; $display("FAIL reset_bics got=%0d want=0", bics); end
        checks++; if (bicr !== 4'd0) begin failures++; $display("FAIL reset_bicr got=%0d want=0", bicr); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        checks++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin failures++; $display("FAIL reset_rx_flags got=%b want=00", {rx_overrun, rx_frame_err}); end
`ifdef SERIAL_LINK_PARITY_EN
        checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b want=0", rx_parity_err); end
`endif
        repeat (20) tick();
        checks++; if ({tx_busy, tx_serial} !== 2'b01) begin failures++; $display("FAIL reset_abort got busy/serial=%b want=01", {tx_busy, tx_serial}); end
    endtask

    task automatic test_tx_frame();
        int bad_bits;
        int early_done;
        logic [DATA_W-1:0] d;
        d = 8'hA5;
        bad_bits = 0;
        early_done = 0;
        tx_data = d;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        checks++; if ({tx_busy, tx_serial} !== 2'b10) begin failures++; $display("FAIL tx_accept got busy/serial=%b want=10", {tx_busy, tx_serial}); end
        checks++; if (bics !== 4'd0) begin failures++; $display("FAIL tx_bics_start got=%0d want=0", bics); end
        for (int k = 0; k < int'(NBITS * CPB); k++) begin
            if (tx_serial !== frame_bit(d, k / int'(CPB))) bad_bits++;
            if (tx_done !== 1'b0) early_done++;
            if (k == 40) begin
                checks++; if (bics !== 4'd1) begin failures++; $display("FAIL tx_bics_mid got=%0d want=1", bics); end
            end
            if (k == int'(DATA_W * CPB + CPB) + 6) begin
                checks++; if (bics !== 4'd8) begin failures++; $display("FAIL tx_bics_full got=%0d want=8", bics); end
            end
            tx_load = (k == 50);
            tx_data = (k == 50) ? 8'h00 : d;
            tick();
        end
        checks++; if (bad_bits != 0) begin failures++; $display("FAIL tx_line_bits got=%0d wrong cycles want=0", bad_bits); end
        checks++; if (early_done != 0) begin failures++; $display("FAIL tx_done_early got=%0d pulses want=0", early_done); end
        checks++; if ({tx_done, tx_busy, tx_serial} !== 3'b101) begin failures++; $display("FAIL tx_done_end got done/busy/serial=%b want=101", {tx_done, tx_busy, tx_serial}); end
        checks++; if (bics !== 4'd8) begin failures++; $display("FAIL tx_bics_hold got=%0d want=8", bics); end
        tick();
        checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL tx_done_single got=%b want=0", tx_done); end
    endtask

    task automatic test_back_to_back();
        int n;
        loop_en = 1'b1;
        tx_data = 8'h3C;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        repeat (NBITS * CPB - 1) tick();
        tx_data = 8'hC3;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        checks++; if ({tx_done, tx_busy, tx_serial} !== 3'b110) begin failures++; $display("FAIL b2b_no_gap got done/busy/serial=%b want=110", {tx_done, tx_busy, tx_serial}); end
        n = 0;
        while (rx_valid !== 1'b1 && n < 400) begin tick(); n++; end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b want=1 (timeout)", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL b2b_first_data got=%h want=3c", rx_data); end
        pulse_ack();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL b2b_ack got=%b want=0", rx_valid); end
        n = 0;
        while (rx_valid !== 1'b1 && n < 400) begin tick(); n++; end
        checks++; if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_data got=%h valid=%b want=c3 valid=1", rx_data, rx_valid); end
        checks++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin failures++; $display("FAIL b2b_flags got=%b want=00", {rx_overrun, rx_frame_err}); end
        pulse_ack();
        n = 0;
        while (tx_busy !== 1'b0 && n < 400) begin tick(); n++; end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_tx_idle got=%b want=0 (timeout)", tx_busy); end
        loop_en = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_glitch();
        rx_drv = 1'b0;
        repeat (5) tick();
        rx_drv = 1'b1;
        repeat (40) tick();
        checks++; if (bicr !== 4'd0) begin failures++; $display("FAIL glitch_bicr got=%0d want=0", bicr); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b want=0", rx_valid); end
        checks++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin failures++; $display("FAIL glitch_flags got=%b want=00", {rx_overrun, rx_frame_err}); end
    endtask

    task automatic test_overrun();
        send_rx(8'h5A, 1'b1, 1'b0);
        checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL ovr_first got valid=%b data=%h want valid=1 data=5a", rx_valid, rx_data); end
        checks++; if (bicr !== 4'd8) begin failures++; $display("FAIL ovr_bicr got=%0d want=8", bicr); end
        send_rx(8'h99, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL ovr_hold_data got=%h want=5a", rx_data); end
        checks++; if ({rx_valid, rx_overrun, rx_frame_err} !== 3'b110) begin failures++; $display("FAIL ovr_flag got valid/ovr/ferr=%b want=110", {rx_valid, rx_overrun, rx_frame_err}); end
        pulse_ack();
        checks++; if ({rx_valid, rx_overrun} !== 2'b00) begin failures++; $display("FAIL ovr_ack got valid/ovr=%b want=00", {rx_valid, rx_overrun}); end
    endtask

    task automatic test_frame_err();
        send_rx(8'h81, 1'b0, 1'b0);
        repeat (20) tick();
        checks++; if ({rx_valid, rx_frame_err, rx_overrun} !== 3'b010) begin failures++; $display("FAIL ferr_set got valid/ferr/ovr=%b want=010", {rx_valid, rx_frame_err, rx_overrun}); end
        pulse_ack();
        checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL ferr_ack got=%b want=0", rx_frame_err); end
`ifdef SERIAL_LINK_PARITY_EN
        send_rx(8'h07, 1'b1, 1'b1);
        checks++; if ({rx_valid, rx_parity_err, rx_frame_err} !== 3'b010) begin failures++; $display("FAIL perr_set got valid/perr/ferr=%b want=010", {rx_valid, rx_parity_err, rx_frame_err}); end
        pulse_ack();
        checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL perr_ack got=%b want=0", rx_parity_err); end
`endif
    endtask

    initial begin
        repeat (3) tick();
        reset_reset = 1'b0;
        tick();
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_glitch();
        test_overrun();
        test_frame_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
